// File: rtl/pcie_perst_seq_pkg.sv
// Shared baseboard definitions for the PERST# sequencer: slot states and timing defaults.
package pcie_perst_seq_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_DLY  = 2'd1,
    S_ON   = 2'd2,
    S_HOLD = 2'd3
  } perst_state_e;

  // Cycle counts at the 2.5 MHz SYSCLK.
  localparam int TIME_100MS = 250000;
  localparam int TIME_1MS   = 2500;

  // Counter must reach max(dly, hold) - 1; never narrower than one bit.
  function automatic int cnt_width(input int dly, input int hold);
    int m;
    m = (dly > hold) ? dly : hold;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pcie_perst_chan.sv
// One drive slot: power-good synchroniser, release/hold state machine and sticky loss flag.
//
// state  | meaning
// S_OFF  | power not good, reset asserted
// S_DLY  | power good, counting the release delay
// S_ON   | reset released (port B only in dual-port mode)
// S_HOLD | minimum assertion time after loss or software reset
module pcie_perst_chan
  import pcie_perst_seq_pkg::*;
#(
  parameter int DLY_CYC  = TIME_100MS,
  parameter int HOLD_CYC = TIME_1MS,
  parameter int CNT_W    = cnt_width(DLY_CYC, HOLD_CYC)
) (
  input  logic SYSCLK,
  input  logic RESET_N,
  input  logic DRV_PWROK,
  input  logic SW_RST_REQ,
  input  logic DUAL_PORT,
  input  logic LOST_CLR,
  output logic PE_RST_A_L,
  output logic PE_RST_B_L,
  output logic PWR_LOST
);

  localparam logic [CNT_W-1:0] DLY_TC  = CNT_W'(DLY_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC - 1);

  logic [1:0]       sync_q;
  logic             pwrok_s;
  perst_state_e     state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             lost_set;
  logic             rst_a_q, rst_b_q, lost_q;

  assign pwrok_s = sync_q[1];

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], DRV_PWROK};
    end
  end

  always_comb begin
    state_nxt = state_q;
    lost_set  = 1'b0;
    case (state_q)
      S_OFF: begin
        if (pwrok_s) state_nxt = S_DLY;
      end
      S_DLY: begin
        if (!pwrok_s)             state_nxt = S_OFF;
        else if (cnt_q == DLY_TC) state_nxt = S_ON;
      end
      S_ON: begin
        if (!pwrok_s) begin
          state_nxt = S_HOLD;
          lost_set  = 1'b1;
        end else if (SW_RST_REQ) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_TC) state_nxt = S_OFF;
      end
      default: state_nxt = S_OFF;
    endcase
  end

  // Counter restarts on every state change; it cannot wrap since both
  // counting states leave at their terminal value.
  always_comb begin
    cnt_nxt = '0;
    if (state_nxt == state_q && (state_q == S_DLY || state_q == S_HOLD)) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Pins follow the next state so they switch on the same edge as the FSM.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_a_q <= 1'b0;
      rst_b_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      rst_a_q <= (state_nxt == S_ON);
      rst_b_q <= (state_nxt == S_ON) && DUAL_PORT;
      if (lost_set)      lost_q <= 1'b1;
      else if (LOST_CLR) lost_q <= 1'b0;
    end
  end

  assign PE_RST_A_L = rst_a_q;
  assign PE_RST_B_L = rst_b_q;
  assign PWR_LOST   = lost_q;

endmodule

// File: rtl/pcie_perst_seq.sv
// PCIe PERST# sequencer for all drive slots; one independent channel per slot.
module pcie_perst_seq
  import pcie_perst_seq_pkg::*;
#(
  parameter int NUM_DRV  = 24,
  parameter int DLY_CYC  = TIME_100MS,
  parameter int HOLD_CYC = TIME_1MS
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  input  logic [NUM_DRV-1:0] DRV_PWROK,
  input  logic [NUM_DRV-1:0] SW_RST_REQ,
  input  logic [NUM_DRV-1:0] DUAL_PORT,
  input  logic [NUM_DRV-1:0] LOST_CLR,
  output logic [NUM_DRV-1:0] PE_RST_A_L,
  output logic [NUM_DRV-1:0] PE_RST_B_L,
  output logic [NUM_DRV-1:0] PWR_LOST
);

  localparam int CNT_W = cnt_width(DLY_CYC, HOLD_CYC);

  for (genvar g = 0; g < NUM_DRV; g++) begin : g_chan
    pcie_perst_chan #(
      .DLY_CYC  (DLY_CYC),
      .HOLD_CYC (HOLD_CYC),
      .CNT_W    (CNT_W)
    ) u_chan (
      .SYSCLK     (SYSCLK),
      .RESET_N    (RESET_N),
      .DRV_PWROK  (DRV_PWROK[g]),
      .SW_RST_REQ (SW_RST_REQ[g]),
      .DUAL_PORT  (DUAL_PORT[g]),
      .LOST_CLR   (LOST_CLR[g]),
      .PE_RST_A_L (PE_RST_A_L[g]),
      .PE_RST_B_L (PE_RST_B_L[g]),
      .PWR_LOST   (PWR_LOST[g])
    );
  end

endmodule

// File: doc/pcie_perst_seq.md
# pcie_perst_seq

Parametrised PCIe PERST# sequencer for the baseboard CPLD. It drives the port-A and port-B reset outputs of NUM_DRV drive slots from each slot's power-good input. Each slot runs an independent state machine: it releases reset a programmable time after power is stable, re-asserts reset immediately on power loss, and honours a minimum assertion time. It also supports per-slot software reset pulses, single/dual-port mode and sticky power-loss flags. It sits between the power-sequencing logic and the drive connectors.

## Interface
Parameters:
- NUM_DRV, 24: number of drive slots.
- DLY_CYC, 250000: SYSCLK cycles of stable power before PERST# release (100 ms at 2.5 MHz). Must be ≥1.
- HOLD_CYC, 2500: minimum PERST# assertion after power loss or software reset (1 ms at 2.5 MHz). Must be ≥1.

Ports:
- SYSCLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- DRV_PWROK  in  NUM_DRV  per-slot power good; asynchronous, active high
- SW_RST_REQ  in  NUM_DRV  per-slot software reset request; synchronous, one-cycle pulse
- DUAL_PORT  in  NUM_DRV  1 = port B in use; synchronous, quasi-static
- LOST_CLR  in  NUM_DRV  clear for PWR_LOST; synchronous pulse
- PE_RST_A_L  out  NUM_DRV  port-A PERST#, active low, registered
- PE_RST_B_L  out  NUM_DRV  port-B PERST#, active low, registered
- PWR_LOST  out  NUM_DRV  sticky flag: power dropped while the slot was in S_ON

## Operation
- Each slot synchronises DRV_PWROK through 2 flops (pwrok_s). No other debounce.
- Each slot has one counter of width CNT_W = $clog2(max(DLY_CYC, HOLD_CYC)). The counter clears on every state entry.
- S_OFF: reset asserted, cnt = 0. Goes to S_DLY when pwrok_s = 1.
- S_DLY: reset asserted, cnt increments.
  - pwrok_s = 0 goes to S_OFF. PWR_LOST is not set.
  - cnt = DLY_CYC−1 with pwrok_s = 1 goes to S_ON.
- S_ON: port A released. Port B released only if DUAL_PORT[i] = 1, otherwise held low.
  - pwrok_s = 0 goes to S_HOLD and sets PWR_LOST[i].
  - SW_RST_REQ[i] = 1 goes to S_HOLD.
  - If both occur in the same cycle: go to S_HOLD and set PWR_LOST.
- S_HOLD: reset asserted, cnt increments. At cnt = HOLD_CYC−1 goes to S_OFF. Power state is ignored in S_HOLD.
- SW_RST_REQ is ignored in S_OFF, S_DLY and S_HOLD.
- PWR_LOST[i] clears on LOST_CLR[i]. If set and clear occur in the same cycle, set wins.
- The counter never wraps. It stops at its terminal value because the state always changes there.

## Timing
- Reset values: every PE_RST_A_L/B_L = 0 (reset asserted while the CPLD is in reset), all states S_OFF, counters 0, PWR_LOST = 0.
- Release latency: DRV_PWROK rises while the slot is in S_OFF at edge 0. pwrok_s is high after edge 2. PE_RST_A_L goes high at edge 3+DLY_CYC.
- Assertion latency: DRV_PWROK falls while the slot is in S_ON at edge 0. PE_RST_A_L/B_L go low at edge 3, and PWR_LOST is high from the same edge.
- Software reset: SW_RST_REQ sampled at edge 0. Outputs go low at edge 1 and stay low for at least HOLD_CYC cycles.
- Earliest re-release after a software reset with power still good: HOLD_CYC + 1 (S_OFF) + DLY_CYC cycles after the outputs went low.
- Outputs are registered from the next-state decode, so the pin toggles on the same edge the state changes.
- DUAL_PORT change in S_ON: PE_RST_B_L follows on the next edge, and port A is unaffected.
- RESET_N asserted mid-operation: all outputs go low asynchronously and every slot restarts the full S_OFF→S_DLY sequence.

## Structure
- Shared baseboard package/define file holds:
  - state encoding localparams S_OFF, S_DLY, S_ON, S_HOLD;
  - timing constants TIME_100MS and TIME_1MS, used as the DLY_CYC/HOLD_CYC defaults.
- Sub-module pcie_perst_chan contains the synchroniser, FSM, counter, output registers and sticky flag for one slot. pcie_perst_seq instantiates it NUM_DRV times in a generate loop.

## Test plan
Configuration for all scenarios: NUM_DRV = 4, DLY_CYC = 10, HOLD_CYC = 4.
- Power-up: RESET_N released, DRV_PWROK[0] rises at edge 0, DUAL_PORT[0] = 1 → PE_RST_A_L[0] and PE_RST_B_L[0] are 0 until edge 12 and 1 from edge 13. Other slots stay 0.
- Glitch before release: DRV_PWROK[1] high for 6 cycles, then low → outputs never rise, PWR_LOST[1] = 0. A later rise is followed by the full 10-cycle wait.
- Power loss in S_ON: DRV_PWROK[2] drops at edge 0 → outputs 0 at edge 3, PWR_LOST[2] = 1. Power restored at edge 4 → release no earlier than HOLD + OFF + DLY after assertion. LOST_CLR pulsed together with a new loss → flag stays 1.
- Software reset and single port: DUAL_PORT[3] = 0 → PE_RST_B_L[3] is always 0. SW_RST_REQ[3] pulse in S_ON → A low for exactly 4+1+10 cycles before re-release. SW_RST_REQ pulsed while in S_DLY → ignored.
- Mid-operation reset: all slots in S_ON, RESET_N pulsed low for 2 cycles → all outputs 0 immediately. Re-release 13 cycles after RESET_N high with power still good. PWR_LOST cleared.
